router_dest_reader: RTL and testbench
=====================================

Name: router_dest_reader

Overview:
- Destination-side consumer for one router output port. It drains the output FIFO by driving read_enb while vld_out is high, and reassembles the packet (header, payload, parity).
- It delivers payload bytes to a downstream sink, checks parity, and reports per-packet status.
- One instance per output port (0/1/2). It is the reader counterpart of the router's synchronizer/FIFO write side and its 30-cycle soft-reset watchdog.

Parameters:
- WIDTH, 8, FIFO data width. Packet format requires 8.
- HOLD_OFF, 0, cycles vld_out must be high in IDLE before the header read is issued (0..31). Used to exercise the router soft-reset timeout.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- vld_out  in  1  FIFO non-empty (router vld_out_n)
- data_out  in  WIDTH  FIFO read data; valid the cycle after a read is issued (read latency 1)
- soft_reset  in  1  router soft_reset_n; FIFO is being flushed
- sink_ready  in  1  downstream can accept bytes; gates new reads only
- read_enb  out  1  FIFO read strobe (combinational)
- rx_data  out  WIDTH  payload byte to sink (registered)
- rx_valid  out  1  rx_data valid, one cycle per payload byte
- pkt_addr  out  2  header[1:0] of current/last packet
- pkt_len  out  6  header[7:2] of current/last packet
- pkt_done  out  1  one-cycle pulse: packet complete
- parity_err  out  1  valid with pkt_done: computed XOR != received parity byte
- pkt_abort  out  1  one-cycle pulse: packet dropped by soft_reset

Behaviour:
- Packet format: header {len[5:0], addr[1:0]}, then len payload bytes, then parity = XOR of header and all payload bytes. len=0 is legal: header then parity only.
- Reset: state IDLE. All counters and outputs 0; read_enb=0.
- Read issue condition: a read is issued in cycle t only if read_enb=1 and vld_out=1 in t. data_out is captured at the end of t+1. rd_q (registered issue) qualifies capture.
- IDLE
  - Hold-off counter counts while vld_out=1. It clears when vld_out=0 or soft_reset=1.
  - read_enb = vld_out & sink_ready & (holdoff_cnt >= HOLD_OFF) & ~soft_reset.
  - If read_enb=1, go to HDR.
- HDR
  - read_enb=0 (one-cycle bubble).
  - Capture header into pkt_addr/pkt_len and seed parity accumulator with it.
  - Set remaining = len+1. Go to BODY.
- BODY
  - read_enb = vld_out & sink_ready & (issued < len+1) & ~soft_reset.
  - Each rd_q capture XORs data_out into the accumulator for payload bytes.
  - Payload captures register rx_data<=data_out and rx_valid<=1 in the next cycle.
  - Capture number len+1 is the parity byte. It is not forwarded.
  - On the parity capture, set parity_err <= (acc != data_out) and go to DONE.
- DONE
  - pkt_done=1 for one cycle, read_enb=0. Return to IDLE.
  - pkt_addr, pkt_len and parity_err hold until the next header is captured.
- Gaps: vld_out or sink_ready low mid-packet only stalls issuing. In-flight captures complete normally. There is no timeout in this block.
- soft_reset=1 in HDR or BODY:
  - read_enb is forced 0 the same cycle.
  - Any capture pending for that cycle is discarded.
  - Counters clear, and the FSM goes to IDLE.
  - pkt_abort pulses the next cycle; pkt_done does not pulse.
- soft_reset in DONE: pkt_done still pulses, with no abort.
- Issued/captured counters are 7 bits (max 64 reads after the header). They never wrap in a legal packet.
- Only one packet is in flight at a time. The next header read is not issued before the IDLE cycle after DONE.

Test Plan:
- Nominal, HOLD_OFF=0, sink_ready=1, FIFO holds 0x0D,0x11,0x22,0x33,0x0D with vld_out high from cycle 0:
  - read_enb high in cycles 0,2,3,4,5.
  - rx_valid cycles 4,5,6 with data 0x11,0x22,0x33.
  - pkt_done cycle 7, parity_err=0, pkt_addr=1, pkt_len=3.
- Same packet with parity byte 0x0C -> pkt_done=1 with parity_err=1; payload still delivered.
- len=0, header 0x02, parity 0x02 -> read_enb cycles 0,2; no rx_valid; pkt_done with parity_err=0 and pkt_addr=2.
- vld_out dropped for 3 cycles after the first payload byte, and sink_ready low for 2 cycles mid-payload -> no read issued while either is low; byte order is preserved; pkt_done only after the parity capture.
- HOLD_OFF=29, vld_out high -> first read_enb in cycle 29. With HOLD_OFF=31 and the router asserting soft_reset at cycle 30 -> no read is issued, holdoff_cnt clears, no pkt_abort.
- soft_reset pulse in BODY after 2 payload bytes -> read_enb=0 that cycle, pkt_abort next cycle, no pkt_done. A following clean packet is received correctly. reset asserted mid-packet -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/router_dest_reader.sv
// Destination-side reader for one router output port: drains the FIFO, reassembles
// header/payload/parity, forwards payload bytes and reports per-packet status.
module router_dest_reader #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HOLD_OFF = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_out,
  input  logic [WIDTH-1:0] data_out,
  input  logic             soft_reset,
  input  logic             sink_ready,
  output logic             read_enb,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [1:0]       pkt_addr,
  output logic [5:0]       pkt_len,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             pkt_abort
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned HO_W  = 5;

  typedef logic [HO_W:0] ho_ext_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [HO_W-1:0]  r_holdoff;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_captured;
  logic [CNT_W-1:0] w_len_p1;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rd_q;
  logic             r_rx_valid;
  logic [1:0]       r_pkt_addr;
  logic [5:0]       r_pkt_len;
  logic             r_pkt_done;
  logic             r_parity_err;
  logic             r_pkt_abort;
  logic             w_holdoff_ok;
  logic             w_parity_cap;
  logic             w_abort;

  assign w_len_p1     = {1'b0, r_pkt_len} + 7'd1;
  // holdoff_cnt >= HOLD_OFF, written so a zero HOLD_OFF is not a constant compare
  assign w_holdoff_ok = (ho_ext_t'(r_holdoff) + ho_ext_t'(1)) > ho_ext_t'(HOLD_OFF);
  // Capture number len+1 (captured count == len before increment) is the parity byte
  assign w_parity_cap = r_rd_q && (r_captured == {1'b0, r_pkt_len});

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    read_enb = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        read_enb = vld_out & sink_ready & w_holdoff_ok & ~soft_reset;
        if (read_enb) w_next = S_HDR;
      end
      S_HDR: begin
        if (soft_reset) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          w_next = S_BODY;
        end
      end
      S_BODY: begin
        if (soft_reset) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end else begin
          read_enb = vld_out & sink_ready & (r_issued < w_len_p1);
          if (w_parity_cap) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture datapath: header latch, parity accumulation, payload forwarding
  always_ff @(posedge clock) begin
    if (reset) begin
      r_holdoff    <= '0;
      r_issued     <= '0;
      r_captured   <= '0;
      r_acc        <= '0;
      r_rx_data    <= '0;
      r_rd_q       <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_pkt_addr   <= '0;
      r_pkt_len    <= '0;
      r_pkt_done   <= 1'b0;
      r_parity_err <= 1'b0;
      r_pkt_abort  <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_abort <= w_abort;
      r_rd_q      <= read_enb;

      if (r_state == S_IDLE && vld_out && !soft_reset) begin
        if (r_holdoff != '1) r_holdoff <= r_holdoff + 5'd1;
      end else begin
        r_holdoff <= '0;
      end

      case (r_state)
        S_HDR: begin
          r_issued   <= '0;
          r_captured <= '0;
          if (!soft_reset) begin
            r_pkt_addr   <= data_out[1:0];
            r_pkt_len    <= data_out[7:2];
            r_acc        <= data_out;
            r_parity_err <= 1'b0;
          end
        end
        S_BODY: begin
          if (soft_reset) begin
            r_issued   <= '0;
            r_captured <= '0;
            r_acc      <= '0;
          end else begin
            if (read_enb) r_issued <= r_issued + 7'd1;
            if (r_rd_q) begin
              r_captured <= r_captured + 7'd1;
              if (w_parity_cap) begin
                r_parity_err <= (r_acc != data_out);
                r_pkt_done   <= 1'b1;
              end else begin
                r_acc      <= r_acc ^ data_out;
                r_rx_data  <= data_out;
                r_rx_valid <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign pkt_addr   = r_pkt_addr;
  assign pkt_len    = r_pkt_len;
  assign pkt_done   = r_pkt_done;
  assign parity_err = r_parity_err;
  assign pkt_abort  = r_pkt_abort;

endmodule

// File: tb/tb_router_dest_reader.sv
// Scoreboard bench for router_dest_reader: FIFO model with read latency 1, expected
// payload/status queues, cycle-accurate read/delivery timing checks.
module tb_router_dest_reader;

  typedef struct packed {
    logic       abort;
    logic [1:0] addr;
    logic [5:0] len;
    logic       perr;
  } pkt_exp_t;

  logic       clock = 1'b0;
  logic       reset, vld_out, soft_reset, sink_ready, vld_en;
  logic [7:0] data_out;
  logic       read_enb, rx_valid, pkt_done, parity_err, pkt_abort;
  logic [7:0] rx_data;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;

  logic       rst2, vld2, sr2;
  logic [7:0] data2;
  logic       read_enb2, rx_valid2, pkt_done2, parity_err2, pkt_abort2;
  logic [7:0] rx_data2;
  logic [1:0] pkt_addr2;
  logic [5:0] pkt_len2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] exp_rx[$];
  pkt_exp_t   exp_pkt[$];
  int         re_log[$], rx_log[$], done_log[$], ab_log[$], re2_log[$], ab2_log[$];

  always #5 clock = ~clock;

  assign vld_out = vld_en && (wr_ptr != rd_ptr);
  assign data2   = 8'h00;

  router_dest_reader #(.WIDTH(8), .HOLD_OFF(0)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .sink_ready(sink_ready), .read_enb(read_enb),
    .rx_data(rx_data), .rx_valid(rx_valid), .pkt_addr(pkt_addr), .pkt_len(pkt_len),
    .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort)
  );

  router_dest_reader #(.WIDTH(8), .HOLD_OFF(29)) dut2 (
    .clock(clock), .reset(rst2), .vld_out(vld2), .data_out(data2),
    .soft_reset(sr2), .sink_ready(1'b1), .read_enb(read_enb2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .pkt_addr(pkt_addr2), .pkt_len(pkt_len2),
    .pkt_done(pkt_done2), .parity_err(parity_err2), .pkt_abort(pkt_abort2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // FIFO model: data valid the cycle after an issued read; flushed on reset/soft_reset
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset || soft_reset) rd_ptr <= wr_ptr;
    else if (read_enb && vld_out) begin
      data_out <= mem[8'(rd_ptr)];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  always @(negedge clock) begin
    pkt_exp_t p;
    logic [7:0] b;
    if (read_enb) begin
      re_log.push_back(cyc);
      chk("re_gate", 32'({vld_out, sink_ready, soft_reset}), 32'd6);
    end
    if (rx_valid) begin
      rx_log.push_back(cyc);
      if (exp_rx.size() == 0) chk("rx_unexpected", 32'(exp_rx.size()), 32'd1);
      else begin
        b = exp_rx.pop_front();
        chk("rx_data", 32'(rx_data), 32'(b));
      end
    end
    if (pkt_done || pkt_abort) begin
      if (pkt_done)  done_log.push_back(cyc);
      if (pkt_abort) ab_log.push_back(cyc);
      if (exp_pkt.size() == 0) chk("pkt_unexpected", 32'(exp_pkt.size()), 32'd1);
      else begin
        p = exp_pkt.pop_front();
        chk("pkt_kind", 32'({pkt_done, pkt_abort}), p.abort ? 32'd1 : 32'd2);
        if (pkt_done) begin
          chk("pkt_addr", 32'(pkt_addr), 32'(p.addr));
          chk("pkt_len", 32'(pkt_len), 32'(p.len));
          chk("parity_err", 32'(parity_err), 32'(p.perr));
        end
      end
    end
    if (read_enb2)  re2_log.push_back(cyc);
    if (pkt_abort2) ab2_log.push_back(cyc);
  end

  task automatic push_byte(input logic [7:0] b);
    mem[8'(wr_ptr)] = b;
    wr_ptr++;
  endtask

  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len, input logic [7:0] pay[$],
                          input logic flip, input logic track);
    logic [7:0] par;
    pkt_exp_t   p;
    par = {len, addr};
    push_byte({len, addr});
    for (int i = 0; i < int'(len); i++) begin
      push_byte(pay[i]);
      par ^= pay[i];
      if (track) exp_rx.push_back(pay[i]);
    end
    if (flip) par ^= 8'h01;
    push_byte(par);
    if (track) begin
      p.abort = 1'b0; p.addr = addr; p.len = len; p.perr = flip;
      exp_pkt.push_back(p);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_rx.size() != 0 || exp_pkt.size() != 0) && k < budget) begin
      @(posedge clock);
      k++;
    end
    chk("drain", 32'(k < budget), 32'd1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string tag, input int log[$], input int t0, input int win,
                           input int exp[$]);
    int got[$];
    foreach (log[i]) if (log[i] >= t0 && log[i] < t0 + win) got.push_back(log[i] - t0);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(tag, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int         t0;
    int         e[$];
    logic [7:0] pl[$];
    pkt_exp_t   p;

    reset = 1'b1; rst2 = 1'b1; vld_en = 1'b0; soft_reset = 1'b0; sink_ready = 1'b1;
    vld2 = 1'b0; sr2 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_read_enb", 32'(read_enb), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_pkt_addr", 32'(pkt_addr), 32'd0);
    chk("rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_pkt_abort", 32'(pkt_abort), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; rst2 = 1'b0; vld_en = 1'b1;
    repeat (2) @(posedge clock);

    // Nominal packet
    @(posedge clock); #1; t0 = cyc;
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd1, 6'd3, pl, 1'b0, 1'b1);
    wait_drain(50);
    e = '{0, 2, 3, 4, 5}; check_log("nom_re", re_log, t0, 12, e);
    e = '{4, 5, 6};       check_log("nom_rx", rx_log, t0, 12, e);
    e = '{7};             check_log("nom_done", done_log, t0, 12, e);

    // Same packet, corrupted parity byte 0x0C
    @(posedge clock); #1; t0 = cyc;
    send_pkt(2'd1, 6'd3, pl, 1'b1, 1'b1);
    wait_drain(50);
    e = '{7}; check_log("bad_done", done_log, t0, 12, e);

    // Zero-length packet
    @(posedge clock); #1; t0 = cyc;
    pl.delete();
    send_pkt(2'd2, 6'd0, pl, 1'b0, 1'b1);
    wait_drain(50);
    e = '{0, 2}; check_log("len0_re", re_log, t0, 12, e);
    e.delete();  check_log("len0_rx", rx_log, t0, 12, e);
    e = '{4};    check_log("len0_done", done_log, t0, 12, e);

    // vld_out gap then sink_ready gap mid-payload
    @(posedge clock); #1; t0 = cyc;
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_pkt(2'd3, 6'd4, pl, 1'b0, 1'b1);
    repeat (3) @(posedge clock); #1; vld_en = 1'b0;
    repeat (3) @(posedge clock); #1; vld_en = 1'b1;
    @(posedge clock); #1; sink_ready = 1'b0;
    repeat (2) @(posedge clock); #1; sink_ready = 1'b1;
    wait_drain(50);
    e = '{0, 2, 6, 9, 10, 11}; check_log("gap_re", re_log, t0, 20, e);
    e = '{4, 8, 11, 12};       check_log("gap_rx", rx_log, t0, 20, e);
    e = '{13};                 check_log("gap_done", done_log, t0, 20, e);

    // soft_reset in BODY after two payload bytes have been delivered
    @(posedge clock); #1; t0 = cyc;
    pl = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    send_pkt(2'd0, 6'd5, pl, 1'b0, 1'b0);
    exp_rx.push_back(8'h51);
    exp_rx.push_back(8'h52);
    p.abort = 1'b1; p.addr = 2'd0; p.len = 6'd0; p.perr = 1'b0;
    exp_pkt.push_back(p);
    repeat (5) @(posedge clock); #1; soft_reset = 1'b1;
    @(negedge clock);
    chk("sr_read_enb", 32'(read_enb), 32'd0);
    @(posedge clock); #1; soft_reset = 1'b0;
    wait_drain(50);
    e = '{4, 5}; check_log("sr_rx", rx_log, t0, 15, e);
    e.delete();  check_log("sr_done", done_log, t0, 15, e);
    e = '{6};    check_log("sr_abort", ab_log, t0, 15, e);

    // Clean packet after the abort
    @(posedge clock); #1;
    pl.delete();
    for (int i = 0; i < 7; i++) pl.push_back(8'($urandom));
    send_pkt(2'($urandom_range(0, 3)), 6'd7, pl, 1'b0, 1'b1);
    wait_drain(60);

    // Hard reset mid-packet
    @(posedge clock); #1;
    pl.delete();
    for (int i = 0; i < 6; i++) pl.push_back(8'($urandom));
    send_pkt(2'd3, 6'd6, pl, 1'b0, 1'b1);
    repeat (5) @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    exp_rx.delete();
    exp_pkt.delete();
    @(negedge clock);
    chk("mid_rst_read_enb", 32'(read_enb), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_pkt_addr", 32'(pkt_addr), 32'd0);
    chk("mid_rst_pkt_len", 32'(pkt_len), 32'd0);
    chk("mid_rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("mid_rst_parity_err", 32'(parity_err), 32'd0);
    chk("mid_rst_pkt_abort", 32'(pkt_abort), 32'd0);
    repeat (2) @(posedge clock); #1;
    pl = '{8'h01, 8'h80};
    send_pkt(2'd2, 6'd2, pl, 1'b0, 1'b1);
    wait_drain(50);

    // Hold-off of 29 cycles before the header read
    @(posedge clock); #1; t0 = cyc; vld2 = 1'b1;
    repeat (40) @(posedge clock); #1;
    e = '{29, 31}; check_log("ho_re", re2_log, t0, 40, e);
    rst2 = 1'b1; vld2 = 1'b0;
    repeat (2) @(posedge clock); #1; rst2 = 1'b0;

    // soft_reset while holding off restarts the hold-off count, no abort
    @(posedge clock); #1; t0 = cyc; vld2 = 1'b1;
    repeat (28) @(posedge clock); #1; sr2 = 1'b1;
    @(posedge clock); #1; sr2 = 1'b0;
    repeat (45) @(posedge clock); #1;
    e = '{58, 60}; check_log("ho_sr_re", re2_log, t0, 70, e);
    e.delete();    check_log("ho_sr_abort", ab2_log, t0, 70, e);
    rst2 = 1'b1; vld2 = 1'b0;
    repeat (2) @(posedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
